// File: rtl/lsu_pkg.sv
// Shared constants and decode helpers for the load/store memory initiator.
package lsu_pkg;

  // FSM encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // RV32I load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Access lengths in bytes
  localparam logic [2:0] LEN_B  = 3'd1;
  localparam logic [2:0] LEN_H  = 3'd2;
  localparam logic [2:0] LEN_W  = 3'd4;

  // Width decode shared by loads and stores; 0 marks an unusable width code.
  function automatic logic [2:0] f3_len(input logic [2:0] f3);
    logic [2:0] len;
    case (f3[1:0])
      2'b00:   len = LEN_B;
      2'b01:   len = LEN_H;
      2'b10:   len = LEN_W;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

  function automatic logic is_load_f3(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_SB, F3_SH, F3_SW: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Natural alignment check on the two low address bits.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] len);
    logic bad;
    case (len)
      LEN_H:   bad = addr_lo[0];
      LEN_W:   bad = |addr_lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational width select and sign/zero extension keyed by RV32I funct3.
// Also used with the unsigned load codes to mask store data to its width.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  // Select byte/half/word and fill the upper bits
  always_comb begin
    case (funct3)
      F3_LB:   ext = {{24{data[7]}}, data[7:0]};
      F3_LH:   ext = {{16{data[15]}}, data[15:0]};
      F3_LBU:  ext = {24'd0, data[7:0]};
      F3_LHU:  ext = {16'd0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: accepts one request, drives the memory port for
// MEM_LATENCY cycles, then returns extended load data or an error response.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_isLoad,
  input  logic        in_isStore,
  input  logic [31:0] in_addr,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_isLoad,
  output logic        mem_isStore,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_len,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  f3_q, f3_d;
  logic        out_valid_q, out_valid_d;
  logic        out_err_q, out_err_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        mem_load_q, mem_load_d;
  logic        mem_store_q, mem_store_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_len_q, mem_len_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        in_ready_s;
  logic        accept_s;
  logic [2:0]  req_len_s;
  logic        f3_ok_s;
  logic        req_ok_s;
  logic [31:0] store_data_s;
  logic [31:0] load_data_s;

  assign in_ready_s = (state_q == ST_IDLE) && !reset;
  assign accept_s   = in_valid && in_ready_s;

  // Store data masked to its width through the unsigned extension codes
  lsu_load_ext u_store_mask (
    .data   (in_wdata),
    .funct3 ({1'b1, in_funct3[1:0]}),
    .ext    (store_data_s)
  );

  // Load data extension from the captured funct3
  lsu_load_ext u_load_ext (
    .data   (mem_rdata),
    .funct3 (f3_q),
    .ext    (load_data_s)
  );

  // Request legality: exactly one of load/store, legal funct3, aligned address
  always_comb begin
    req_len_s = f3_len(in_funct3);
    if (in_isLoad && !in_isStore) begin
      f3_ok_s = is_load_f3(in_funct3);
    end else if (in_isStore && !in_isLoad) begin
      f3_ok_s = is_store_f3(in_funct3);
    end else begin
      f3_ok_s = 1'b0;
    end
    req_ok_s = f3_ok_s && !misaligned(in_addr[1:0], req_len_s);
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    f3_d        = f3_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_rdata_d = out_rdata_q;
    mem_load_d  = mem_load_q;
    mem_store_d = mem_store_q;
    mem_addr_d  = mem_addr_q;
    mem_len_d   = mem_len_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && req_ok_s) begin
          state_d     = ST_ACCESS;
          cnt_d       = LAT_INIT;
          is_load_d   = in_isLoad;
          f3_d        = in_funct3;
          mem_addr_d  = in_addr;
          mem_len_d   = req_len_s;
          mem_wdata_d = in_isStore ? store_data_s : 32'd0;
          mem_load_d  = in_isLoad;
          mem_store_d = in_isStore;
        end else if (accept_s) begin
          // Bad request: answer immediately, memory is never touched
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          out_rdata_d = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // The write strobe lives only in the first access cycle
        mem_store_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d     = ST_DONE;
          mem_load_d  = 1'b0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
          out_rdata_d = is_load_q ? load_data_s : 32'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = 32'd0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        mem_load_d  = 1'b0;
        mem_store_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      is_load_q   <= 1'b0;
      f3_q        <= 3'd0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_rdata_q <= 32'd0;
      mem_load_q  <= 1'b0;
      mem_store_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_len_q   <= 3'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      f3_q        <= f3_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_rdata_q <= out_rdata_d;
      mem_load_q  <= mem_load_d;
      mem_store_q <= mem_store_d;
      mem_addr_q  <= mem_addr_d;
      mem_len_q   <= mem_len_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_rdata   = out_rdata_q;
  assign out_err     = out_err_q;
  assign mem_isLoad  = mem_load_q;
  assign mem_isStore = mem_store_q;
  assign mem_addr    = mem_addr_q;
  assign mem_len     = {29'd0, mem_len_q};
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench: three instances with MEM_LATENCY 1, 3 and 4 share request
// inputs; each has its own in_valid and its own outputs.
module tb_lsu_mem_initiator;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        in_valid = 3'b000;
  logic [2:0]        in_ready;
  logic              in_isLoad = 1'b0;
  logic              in_isStore = 1'b0;
  logic [31:0]       in_addr = 32'd0;
  logic [2:0]        in_funct3 = 3'd0;
  logic [31:0]       in_wdata = 32'd0;
  logic [2:0]        out_valid;
  logic              out_ready = 1'b1;
  logic [2:0][31:0]  out_rdata;
  logic [2:0]        out_err;
  logic [2:0]        mem_isLoad;
  logic [2:0]        mem_isStore;
  logic [2:0][31:0]  mem_addr;
  logic [2:0][31:0]  mem_len;
  logic [2:0][31:0]  mem_wdata;
  logic [31:0]       mem_rdata = 32'd0;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_mem_initiator #(.MEM_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))) u_dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready[g]),
      .in_isLoad   (in_isLoad),
      .in_isStore  (in_isStore),
      .in_addr     (in_addr),
      .in_funct3   (in_funct3),
      .in_wdata    (in_wdata),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready),
      .out_rdata   (out_rdata[g]),
      .out_err     (out_err[g]),
      .mem_isLoad  (mem_isLoad[g]),
      .mem_isStore (mem_isStore[g]),
      .mem_addr    (mem_addr[g]),
      .mem_len     (mem_len[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata)
    );
  end

  // Present a request to instance u for one edge; returns #1 into cycle N+1.
  task automatic issue(input int u, input logic ld, input logic st,
                       input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    in_isLoad  = ld;
    in_isStore = st;
    in_addr    = a;
    in_funct3  = f3;
    in_wdata   = wd;
    in_valid[u] = 1'b1;
    @(posedge clock); #1;
    in_valid[u] = 1'b0;
  endtask

  // Walk cycles from N+1 until out_valid; lat is the cycle offset (0 = timeout).
  task automatic wait_resp(input int u, output int lat, output int nld, output int nst);
    int k;
    k = 0; lat = 0; nld = 0; nst = 0;
    while ((lat == 0) && (k < 40)) begin
      k++;
      if (out_valid[u] === 1'b1) begin
        lat = k;
      end else begin
        nld = nld + ((mem_isLoad[u] === 1'b1) ? 1 : 0);
        nst = nst + ((mem_isStore[u] === 1'b1) ? 1 : 0);
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    for (int g = 0; g < 3; g++) begin
      vec_cnt++; if (in_ready[g] !== 1'b0) begin err_cnt++; $display("FAIL rst_in_ready[%0d] got %b exp 0", g, in_ready[g]); end
      vec_cnt++; if (out_valid[g] !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid[%0d] got %b exp 0", g, out_valid[g]); end
      vec_cnt++; if ({mem_isLoad[g], mem_isStore[g], out_err[g]} !== 3'b000) begin err_cnt++; $display("FAIL rst_strobes[%0d] got %b exp 000", g, {mem_isLoad[g], mem_isStore[g], out_err[g]}); end
      vec_cnt++; if ((out_rdata[g] | mem_addr[g] | mem_len[g] | mem_wdata[g]) !== 32'd0) begin err_cnt++; $display("FAIL rst_data[%0d] got %h exp 0", g, out_rdata[g] | mem_addr[g] | mem_len[g] | mem_wdata[g]); end
    end
    reset = 1'b0;
    #1;
    vec_cnt++; if (in_ready !== 3'b111) begin err_cnt++; $display("FAIL rst_release_ready got %b exp 111", in_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_load_ext();
    int lat, nld, nst;
    // LB, latency 1, sign-extended byte
    mem_rdata = 32'h00000080;
    issue(0, 1'b1, 1'b0, 32'h80000003, 3'b000, 32'd0);
    vec_cnt++; if (mem_len[0] !== 32'd1) begin err_cnt++; $display("FAIL lb_len got %0d exp 1", mem_len[0]); end
    vec_cnt++; if (mem_addr[0] !== 32'h80000003) begin err_cnt++; $display("FAIL lb_addr got %h exp 80000003", mem_addr[0]); end
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL lb_latency got %0d exp 2", lat); end
    vec_cnt++; if (nld !== 1 || nst !== 0) begin err_cnt++; $display("FAIL lb_strobes got ld=%0d st=%0d exp ld=1 st=0", nld, nst); end
    vec_cnt++; if (out_rdata[0] !== 32'hFFFFFF80) begin err_cnt++; $display("FAIL lb_rdata got %h exp ffffff80", out_rdata[0]); end
    vec_cnt++; if (out_err[0] !== 1'b0) begin err_cnt++; $display("FAIL lb_err got %b exp 0", out_err[0]); end
    vec_cnt++; if (in_ready[0] !== 1'b0) begin err_cnt++; $display("FAIL lb_ready_done got %b exp 0", in_ready[0]); end
    @(posedge clock); #1;
    vec_cnt++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin err_cnt++; $display("FAIL lb_return_idle got v=%b r=%b exp v=0 r=1", out_valid[0], in_ready[0]); end
    // LHU, latency 3, zero-extended half
    mem_rdata = 32'h00008001;
    issue(1, 1'b1, 1'b0, 32'h80000002, 3'b101, 32'd0);
    vec_cnt++; if (mem_len[1] !== 32'd2) begin err_cnt++; $display("FAIL lhu_len got %0d exp 2", mem_len[1]); end
    wait_resp(1, lat, nld, nst);
    vec_cnt++; if (lat !== 4) begin err_cnt++; $display("FAIL lhu_latency got %0d exp 4", lat); end
    vec_cnt++; if (nld !== 3) begin err_cnt++; $display("FAIL lhu_ld_cycles got %0d exp 3", nld); end
    vec_cnt++; if (out_rdata[1] !== 32'h00008001) begin err_cnt++; $display("FAIL lhu_rdata got %h exp 00008001", out_rdata[1]); end
    @(posedge clock); #1;
    // LH, latency 3, sign-extended half, upper garbage dropped
    mem_rdata = 32'hABCD8001;
    issue(1, 1'b1, 1'b0, 32'h80000006, 3'b001, 32'd0);
    wait_resp(1, lat, nld, nst);
    vec_cnt++; if (out_rdata[1] !== 32'hFFFF8001) begin err_cnt++; $display("FAIL lh_rdata got %h exp ffff8001", out_rdata[1]); end
    @(posedge clock); #1;
    // LBU, latency 1, zero-extended byte
    mem_rdata = 32'h123456F0;
    issue(0, 1'b1, 1'b0, 32'h00000001, 3'b100, 32'd0);
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (out_rdata[0] !== 32'h000000F0) begin err_cnt++; $display("FAIL lbu_rdata got %h exp 000000f0", out_rdata[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_store();
    int lat, nld, nst;
    mem_rdata = 32'hCAFEF00D;
    issue(0, 1'b0, 1'b1, 32'h80000010, 3'b001, 32'h12345678);
    vec_cnt++; if (mem_len[0] !== 32'd2) begin err_cnt++; $display("FAIL sh_len got %0d exp 2", mem_len[0]); end
    vec_cnt++; if (mem_wdata[0] !== 32'h00005678) begin err_cnt++; $display("FAIL sh_wdata got %h exp 00005678", mem_wdata[0]); end
    vec_cnt++; if (mem_addr[0] !== 32'h80000010) begin err_cnt++; $display("FAIL sh_addr got %h exp 80000010", mem_addr[0]); end
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 2 || nst !== 1 || nld !== 0) begin err_cnt++; $display("FAIL sh_strobes got lat=%0d st=%0d ld=%0d exp 2/1/0", lat, nst, nld); end
    vec_cnt++; if (out_rdata[0] !== 32'd0 || out_err[0] !== 1'b0) begin err_cnt++; $display("FAIL sh_resp got %h err=%b exp 0 err=0", out_rdata[0], out_err[0]); end
    @(posedge clock); #1;
    // SB on latency 3: one write strobe over a three-cycle access
    issue(1, 1'b0, 1'b1, 32'h80000021, 3'b000, 32'hAABBCCDD);
    vec_cnt++; if (mem_len[1] !== 32'd1 || mem_wdata[1] !== 32'h000000DD) begin err_cnt++; $display("FAIL sb_len_wdata got %0d/%h exp 1/000000dd", mem_len[1], mem_wdata[1]); end
    wait_resp(1, lat, nld, nst);
    vec_cnt++; if (lat !== 4 || nst !== 1 || nld !== 0) begin err_cnt++; $display("FAIL sb_strobes got lat=%0d st=%0d ld=%0d exp 4/1/0", lat, nst, nld); end
    @(posedge clock); #1;
  endtask

  task automatic test_errors();
    int lat, nld, nst;
    mem_rdata = 32'hFFFFFFFF;
    // SW misaligned
    issue(0, 1'b0, 1'b1, 32'h80000002, 3'b010, 32'h11111111);
    vec_cnt++; if (mem_isStore[0] !== 1'b0 || mem_isLoad[0] !== 1'b0) begin err_cnt++; $display("FAIL sw_mis_strobe got st=%b ld=%b exp 0/0", mem_isStore[0], mem_isLoad[0]); end
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 1 || out_err[0] !== 1'b1 || out_rdata[0] !== 32'd0) begin err_cnt++; $display("FAIL sw_mis_resp got lat=%0d err=%b rd=%h exp 1/1/0", lat, out_err[0], out_rdata[0]); end
    @(posedge clock); #1;
    vec_cnt++; if (mem_isStore[0] !== 1'b0 || out_valid[0] !== 1'b0) begin err_cnt++; $display("FAIL sw_mis_after got st=%b v=%b exp 0/0", mem_isStore[0], out_valid[0]); end
    // Illegal load funct3 011
    issue(0, 1'b1, 1'b0, 32'h00000000, 3'b011, 32'd0);
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 1 || out_err[0] !== 1'b1 || mem_isLoad[0] !== 1'b0) begin err_cnt++; $display("FAIL ld_f3_011 got lat=%0d err=%b ld=%b exp 1/1/0", lat, out_err[0], mem_isLoad[0]); end
    @(posedge clock); #1;
    // Both load and store on latency 3: still an immediate error
    issue(1, 1'b1, 1'b1, 32'h00000000, 3'b010, 32'd0);
    wait_resp(1, lat, nld, nst);
    vec_cnt++; if (lat !== 1 || out_err[1] !== 1'b1 || mem_isLoad[1] !== 1'b0 || mem_isStore[1] !== 1'b0) begin err_cnt++; $display("FAIL both_flags got lat=%0d err=%b exp 1/1", lat, out_err[1]); end
    @(posedge clock); #1;
    // Misaligned LH, and illegal store funct3 100
    issue(1, 1'b1, 1'b0, 32'h80000001, 3'b001, 32'd0);
    wait_resp(1, lat, nld, nst);
    vec_cnt++; if (lat !== 1 || out_err[1] !== 1'b1) begin err_cnt++; $display("FAIL lh_mis got lat=%0d err=%b exp 1/1", lat, out_err[1]); end
    @(posedge clock); #1;
    issue(0, 1'b0, 1'b1, 32'h00000000, 3'b100, 32'd0);
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 1 || out_err[0] !== 1'b1) begin err_cnt++; $display("FAIL st_f3_100 got lat=%0d err=%b exp 1/1", lat, out_err[0]); end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int lat, nld, nst;
    mem_rdata = 32'hDEADBEEF;
    out_ready = 1'b0;
    issue(0, 1'b1, 1'b0, 32'h80000004, 3'b010, 32'd0);
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 2) begin err_cnt++; $display("FAIL bp_latency got %0d exp 2", lat); end
    mem_rdata = 32'h00000000;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++; if (out_valid[0] !== 1'b1 || out_rdata[0] !== 32'hDEADBEEF || in_ready[0] !== 1'b0) begin err_cnt++; $display("FAIL bp_hold[%0d] got v=%b rd=%h r=%b exp 1/deadbeef/0", i, out_valid[0], out_rdata[0], in_ready[0]); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    vec_cnt++; if (out_valid[0] !== 1'b1) begin err_cnt++; $display("FAIL bp_still_valid got %b exp 1", out_valid[0]); end
    @(posedge clock); #1;
    vec_cnt++; if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin err_cnt++; $display("FAIL bp_release got v=%b r=%b exp 0/1", out_valid[0], in_ready[0]); end
  endtask

  task automatic test_reset_mid();
    int lat, nld, nst, nv;
    mem_rdata = 32'h55555555;
    issue(2, 1'b1, 1'b0, 32'h80000008, 3'b010, 32'd0);
    vec_cnt++; if (mem_isLoad[2] !== 1'b1) begin err_cnt++; $display("FAIL rm_access1 got %b exp 1", mem_isLoad[2]); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    vec_cnt++; if (mem_isLoad[2] !== 1'b0 || out_valid[2] !== 1'b0 || in_ready[2] !== 1'b0) begin err_cnt++; $display("FAIL rm_abort got ld=%b v=%b r=%b exp 0/0/0", mem_isLoad[2], out_valid[2], in_ready[2]); end
    reset = 1'b0;
    #1;
    vec_cnt++; if (in_ready[2] !== 1'b1) begin err_cnt++; $display("FAIL rm_ready got %b exp 1", in_ready[2]); end
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      nv = nv + ((out_valid[2] !== 1'b0 || mem_isLoad[2] !== 1'b0) ? 1 : 0);
      @(posedge clock); #1;
    end
    vec_cnt++; if (nv !== 0) begin err_cnt++; $display("FAIL rm_no_response got %0d active cycles exp 0", nv); end
    mem_rdata = 32'h01234567;
    issue(2, 1'b1, 1'b0, 32'h8000000C, 3'b010, 32'd0);
    wait_resp(2, lat, nld, nst);
    vec_cnt++; if (lat !== 5 || nld !== 4 || out_rdata[2] !== 32'h01234567) begin err_cnt++; $display("FAIL rm_next got lat=%0d ld=%0d rd=%h exp 5/4/01234567", lat, nld, out_rdata[2]); end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    int lat, nld, nst;
    mem_rdata = 32'h000000F0;
    issue(0, 1'b1, 1'b0, 32'h00000001, 3'b100, 32'd0);
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 2 || out_rdata[0] !== 32'h000000F0) begin err_cnt++; $display("FAIL b2b_first got lat=%0d rd=%h exp 2/000000f0", lat, out_rdata[0]); end
    // Offer the next request while DONE: it must wait for IDLE
    mem_rdata  = 32'h89ABCDEF;
    in_isLoad  = 1'b1;
    in_isStore = 1'b0;
    in_addr    = 32'h00000008;
    in_funct3  = 3'b010;
    in_valid[0] = 1'b1;
    @(posedge clock); #1;
    vec_cnt++; if (mem_isLoad[0] !== 1'b0 || in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin err_cnt++; $display("FAIL b2b_no_accept_in_done got ld=%b r=%b v=%b exp 0/1/0", mem_isLoad[0], in_ready[0], out_valid[0]); end
    @(posedge clock); #1;
    in_valid[0] = 1'b0;
    vec_cnt++; if (mem_isLoad[0] !== 1'b1 || mem_addr[0] !== 32'h00000008) begin err_cnt++; $display("FAIL b2b_second_issue got ld=%b a=%h exp 1/00000008", mem_isLoad[0], mem_addr[0]); end
    wait_resp(0, lat, nld, nst);
    vec_cnt++; if (lat !== 2 || out_rdata[0] !== 32'h89ABCDEF) begin err_cnt++; $display("FAIL b2b_second got lat=%0d rd=%h exp 2/89abcdef", lat, out_rdata[0]); end
    @(posedge clock); #1;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_load_ext();
    test_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
